// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
// Shared constants and types for the two-requester block-RAM port arbiter.
//   ADDR_W_DEF : default RAM address width (512 words)
//   DATA_W_DEF : default RAM word width
//   NUM_REQ    : number of requesters sharing the single RAM port
//   rsp_tag_t  : one-hot requester tag, ascending [0:NUM_REQ-1], bit 0 = MSB
// Optional feature macro used by the top level: BRAM_ARB_OUT_REG_EN
// ---------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 40;
  localparam int NUM_REQ    = 2;

  // Bit i set means requester i; index 0 is the MSB to match the RAM macros.
  typedef logic [0:NUM_REQ-1] rsp_tag_t;

  // Index of the requester named by a one-hot (or zero) tag. A zero tag
  // returns 0; callers qualify the result with their own valid.
  function automatic logic tag_idx(input rsp_tag_t tag);
    return tag[1];
  endfunction

endpackage : bram_arb_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic, purely combinational.
//   i_valid : per-requester request, ascending [0:1], bit 0 = requester 0
//   i_ptr   : index of the requester favoured when both request
//   o_grant : one-hot (or zero) grant, same bit order as i_valid
// A lone requester always wins; the pointer only breaks ties.
// ---------------------------------------------------------------------------
module rr_arb2
  import bram_arb_pkg::*;
(
  input  rsp_tag_t i_valid,
  input  logic     i_ptr,
  output rsp_tag_t o_grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_grant; no latch.
    o_grant = '0;
    if (i_valid[0] && i_valid[1]) begin
      o_grant[i_ptr] = 1'b1;
    end else begin
      o_grant = i_valid;
    end
  end

endmodule : rr_arb2

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
// Shares one single-port block RAM (1-cycle registered read, read-old-data
// on write) between two requesters with round-robin arbitration.
//
// Ports (all vectors ascending [0:N-1], index 0 = MSB, requester 0 first):
//   clk, rst_n              : clock (rising edge), async active-low reset
//   rq_valid / rq_ready     : per-requester handshake, transfer = both high
//   rq_we, rq_addr, rq_wdata: per-requester command fields (2 x width)
//   rsp_valid, rsp_rdata    : read return, one-hot tag, no backpressure
//   mem_addr, mem_datain,
//   mem_we, mem_dataout     : RAM port
//
// Read latency is 1 cycle by default. Defining BRAM_ARB_OUT_REG_EN adds one
// output register stage on rsp_valid/rsp_rdata (latency 2).
// ---------------------------------------------------------------------------
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  rsp_tag_t                  rq_valid,
  output rsp_tag_t                  rq_ready,
  input  rsp_tag_t                  rq_we,
  input  logic [0:NUM_REQ*ADDR_W-1] rq_addr,
  input  logic [0:NUM_REQ*DATA_W-1] rq_wdata,
  output rsp_tag_t                  rsp_valid,
  output logic [0:DATA_W-1]         rsp_rdata,
  output logic [0:ADDR_W-1]         mem_addr,
  output logic [0:DATA_W-1]         mem_datain,
  output logic                      mem_we,
  input  logic [0:DATA_W-1]         mem_dataout
);

  rsp_tag_t          w_grant;
  logic              w_xfer;
  logic              w_sel;
  logic              w_sel_we;
  logic [0:ADDR_W-1] w_sel_addr;
  logic [0:DATA_W-1] w_sel_wdata;

  logic              r_ptr;
  logic [0:ADDR_W-1] r_last_addr;
  logic [0:DATA_W-1] r_last_wdata;
  rsp_tag_t          r_rd_tag;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .i_valid (rq_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Ready is gated by rst_n so that nothing is accepted while reset is held,
  // even though the grant logic itself is purely combinational.
  assign rq_ready = rst_n ? w_grant : '0;
  assign w_xfer   = |rq_ready;
  assign w_sel    = tag_idx(rq_ready);
  assign w_sel_we = rq_we[w_sel];

  always_comb begin
    w_sel_addr  = rq_addr[0 +: ADDR_W];
    w_sel_wdata = rq_wdata[0 +: DATA_W];
    if (w_sel) begin
      w_sel_addr  = rq_addr[ADDR_W +: ADDR_W];
      w_sel_wdata = rq_wdata[DATA_W +: DATA_W];
    end
  end

  // -------------------------------------------------------------------------
  // RAM command: the granted command goes straight to the RAM in the same
  // cycle; without a transfer the address/data hold their last value so the
  // RAM sees a quiet bus.
  // -------------------------------------------------------------------------
  assign mem_we     = w_xfer & w_sel_we;
  assign mem_addr   = w_xfer ? w_sel_addr  : r_last_addr;
  assign mem_datain = w_xfer ? w_sel_wdata : r_last_wdata;

  // Pointer, held command and read tracking. r_rd_tag marks the requester
  // whose read was accepted last cycle, i.e. whose data is on mem_dataout
  // now. Writes never set it, so the RAM's read-old-data is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= 1'b0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rd_tag     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_rd_tag <= (w_xfer && !w_sel_we) ? rq_ready : '0;
      if (w_xfer) begin
        r_ptr        <= ~w_sel;
        r_last_addr  <= w_sel_addr;
        r_last_wdata <= w_sel_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response path
  // -------------------------------------------------------------------------
`ifdef BRAM_ARB_OUT_REG_EN
  rsp_tag_t          r_rsp_valid;
  logic [0:DATA_W-1] r_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= r_rd_tag;
      if (|r_rd_tag) begin
        r_rsp_rdata <= mem_dataout;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`else
  logic [0:DATA_W-1] r_rdata_hold;

  // Captures each returned word so rsp_rdata keeps it once rsp_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_hold <= '0;
    end else if (|r_rd_tag) begin
      r_rdata_hold <= mem_dataout;
    end
  end

  assign rsp_valid = r_rd_tag;
  assign rsp_rdata = (|r_rd_tag) ? mem_dataout : r_rdata_hold;
`endif

  // -------------------------------------------------------------------------
  // Sanity properties (simulation only; synthesis ignores them)
  // -------------------------------------------------------------------------
  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rq_ready));
  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (rq_ready & ~rq_valid) == '0);
  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid));

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
// Self-checking bench for bram_port_arbiter. Inputs are driven on the falling
// edge; outputs are compared on the falling edge (registered) and 1 ns after
// driving (combinational). A behavioural RAM sits on the memory port and a
// reference model (last-granted index, shadow memory, response queue)
// produces all expected values. Honours BRAM_ARB_OUT_REG_EN.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 40;
`ifdef BRAM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic [0:1]       rq_valid;
  logic [0:1]       rq_ready;
  logic [0:1]       rq_we;
  logic [0:2*AW-1]  rq_addr;
  logic [0:2*DW-1]  rq_wdata;
  logic [0:1]       rsp_valid;
  logic [0:DW-1]    rsp_rdata;
  logic [0:AW-1]    mem_addr;
  logic [0:DW-1]    mem_datain;
  logic             mem_we;
  logic [0:DW-1]    mem_dataout;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rq_valid    (rq_valid),
    .rq_ready    (rq_ready),
    .rq_we       (rq_we),
    .rq_addr     (rq_addr),
    .rq_wdata    (rq_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM: registered read, read-old-data on write.
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_datain;
    mem_dataout <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- model
  typedef struct {
    int            due;
    logic [0:1]    tag;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] shadow [512];
  int            last_gnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_hold;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  bit mon_en   = 0;
  bit saw_rsp  = 0;

  always @(negedge clk) if (mon_en && rsp_valid != 2'b00) saw_rsp = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_gnt = -1;
    m_addr   = '0;
    m_wdata  = '0;
    m_hold   = '0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input logic [0:1] v, input logic [0:1] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic [0:1] got_ready, output logic got_we);
    logic [0:1] e_valid;
    logic [0:1] e_ready;
    int g;
    e_valid = 2'b00;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_valid = exp_q[0].tag;
      m_hold  = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_hold));
    check("rsp_onehot", 64'($onehot0(rsp_valid)), 64'd1);

    rq_valid = v;
    rq_we    = we;
    rq_addr  = {a0, a1};
    rq_wdata = {d0, d1};
    #1;
    if (v == 2'b11)  g = (last_gnt == 0) ? 1 : 0;
    else if (v[0])   g = 0;
    else if (v[1])   g = 1;
    else             g = -1;
    e_ready = (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
    if (g >= 0) begin
      m_addr  = (g == 0) ? a0 : a1;
      m_wdata = (g == 0) ? d0 : d1;
    end
    check("rq_ready", 64'(rq_ready), 64'(e_ready));
    check("mem_we", 64'(mem_we), 64'((g >= 0) && we[g]));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_datain", 64'(mem_datain), 64'(m_wdata));
    got_ready = rq_ready;
    got_we    = mem_we;
    if (mem_we) we_cnt++;

    if (g >= 0) begin
      last_gnt = g;
      if (we[g]) shadow[m_addr] = m_wdata;
      else exp_q.push_back('{cyc + LAT, e_ready, shadow[m_addr]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [0:1] r;
    logic w;
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0, r, w);
  endtask

  // Holds reset for n cycles with busy inputs; every output must read 0.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    rq_valid = 2'b11;
    rq_we    = 2'b11;
    rq_addr  = {9'h1FF, 9'h1FE};
    rq_wdata = '1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_rq_ready",   64'(rq_ready),   64'd0);
      check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
      check("rst_mem_we",     64'(mem_we),     64'd0);
      check("rst_mem_addr",   64'(mem_addr),   64'd0);
      check("rst_mem_datain", 64'(mem_datain), 64'd0);
      check("rst_rsp_rdata",  64'(rsp_rdata),  64'd0);
      @(negedge clk);
    end
    rq_valid = 2'b00;
    rq_we    = 2'b00;
    rst_n    = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [0:1]    v;
    logic [0:1]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [0:1]    exp_ready;
    logic          exp_we;
  } vec_t;

  vec_t tbl [12];
  logic [0:1] cont_exp [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [0:1] gr;
    logic       gw;

    // Arbitration table, starting from reset (pointer favours requester 0).
    tbl[0]  = '{2'b11, 2'b00, 9'h010, 9'h011, 40'h0,          40'h0,          2'b10, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 9'h012, 9'h013, 40'h0,          40'h0,          2'b01, 1'b0};
    tbl[2]  = '{2'b10, 2'b00, 9'h014, 9'h015, 40'h0,          40'h0,          2'b10, 1'b0};
    tbl[3]  = '{2'b10, 2'b01, 9'h016, 9'h017, 40'h0,          40'h77,         2'b10, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 9'h018, 9'h019, 40'h0,          40'h0,          2'b01, 1'b0};
    tbl[5]  = '{2'b00, 2'b00, 9'h01A, 9'h01B, 40'h0,          40'h0,          2'b00, 1'b0};
    tbl[6]  = '{2'b01, 2'b00, 9'h01C, 9'h01D, 40'h0,          40'h0,          2'b01, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 9'h01E, 9'h01F, 40'h0,          40'h0,          2'b10, 1'b0};
    tbl[8]  = '{2'b11, 2'b11, 9'h020, 9'h021, 40'hAA_0000_0001, 40'hBB_0000_0002, 2'b01, 1'b1};
    tbl[9]  = '{2'b11, 2'b10, 9'h021, 9'h022, 40'hCC_0000_0003, 40'h0,          2'b10, 1'b1};
    tbl[10] = '{2'b01, 2'b01, 9'h023, 9'h021, 40'h0,          40'hDD_0000_0004, 2'b01, 1'b1};
    tbl[11] = '{2'b11, 2'b01, 9'h021, 9'h024, 40'h0,          40'hEE_0000_0005, 2'b10, 1'b0};
    cont_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    for (int i = 0; i < 512; i++) begin
      ram[i]    = 40'({$urandom(), $urandom()});
      shadow[i] = ram[i];
    end
    model_reset();
    rst_n = 1'b0; rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0;
    @(negedge clk);
    apply_reset(3);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, gr, gw);
      check("tbl_ready", 64'(gr), 64'(tbl[i].exp_ready));
      check("tbl_mem_we", 64'(gw), 64'(tbl[i].exp_we));
    end
    idle(3);

    // Write then read same address on consecutive cycles.
    step(2'b10, 2'b10, 9'h1A3, 9'h000, 40'h12345ABCDE, 40'h0, gr, gw);
    step(2'b10, 2'b00, 9'h1A3, 9'h000, 40'h0, 40'h0, gr, gw);
    check("wr_rd_valid_n1", 64'(rsp_valid), (LAT == 1) ? 64'h2 : 64'h0);
    idle(1);
    check("wr_rd_valid_n2", 64'(rsp_valid), (LAT == 2) ? 64'h2 : 64'h0);
    check("wr_rd_data", 64'(rsp_rdata), 64'h12345ABCDE);
    idle(2);

    // Reset asserted right after a read is accepted: no response, ever.
    rq_valid = 2'b10; rq_we = 2'b00; rq_addr = {9'd5, 9'd0}; rq_wdata = '0;
    #1;
    check("rmr_ready", 64'(rq_ready), 64'h2);
    saw_rsp = 0;
    mon_en  = 1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset(3);
    // First rising edge after reset release must accept.
    step(2'b01, 2'b00, 9'h000, 9'h033, 40'h0, 40'h0, gr, gw);
    check("post_rst_accept", 64'(gr), 64'h1);
    check("rmr_no_rsp", 64'(saw_rsp), 64'd0);
    mon_en = 0;
    idle(2);

    // Contention: both read for six cycles.
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 2'b00, 9'(50 + k), 9'(60 + k), 40'h0, 40'h0, gr, gw);
      check("cont_grant", 64'(gr), 64'(cont_exp[k]));
      if (k >= LAT - 1) check("cont_tag", 64'(rsp_valid), 64'(cont_exp[k - (LAT - 1)]));
    end

    // Lone requester 1, four back-to-back grants.
    for (int k = 0; k < 4; k++) begin
      step(2'b01, 2'b00, 9'h000, 9'(70 + k), 40'h0, 40'h0, gr, gw);
      check("single_r1", 64'(gr), 64'h1);
    end
    idle(3);

    // Write produces no response and exactly one write strobe.
    we_cnt  = 0;
    saw_rsp = 0;
    mon_en  = 1;
    step(2'b01, 2'b01, 9'h000, 9'd7, 40'h0, 40'h5A5A5A5A5A, gr, gw);
    idle(3);
    mon_en = 0;
    check("wr_we_count", 64'(we_cnt), 64'd1);
    check("wr_no_rsp", 64'(saw_rsp), 64'd0);

    // Random traffic over a small address window to exercise RAW hazards.
    for (int k = 0; k < 400; k++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
           40'({$urandom(), $urandom()}), 40'({$urandom(), $urandom()}), gr, gw);
    end
    idle(LAT + 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bram_port_arbiter
